// File: rtl/pause_sequencer.sv
// Fixed-priority pause arbiter that turns a winning request into a vblank-aligned CPU halt
// handshake, with a forced pause on ack timeout and delayed video dimming while paused.
module pause_sequencer #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ACK_TO     = 1024,
    parameter int unsigned DIM_CYCLES = 30000000
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_en,
    input  logic            vblank,
    input  logic            halt_ack,
    input  logic            dim_enable,
    output logic            pause_cpu,
    output logic            paused,
    output logic [NREQ-1:0] grant,
    output logic            dim_video,
    output logic            ack_timeout
);

    typedef enum logic [2:0] {
        StRun,
        StWaitVbl,
        StHalt,
        StPaused,
        StRelease
    } state_e;

    localparam logic [NREQ-1:0] One = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [NREQ-1:0] eff, eff_low, grant_d;
    logic            pause_cpu_d, paused_d, dim_video_d, ack_timeout_d;
    logic            vblank_prev, vbl_rise, stay_paused;
    logic [31:0]     ack_cnt_q, ack_cnt_d, dim_cnt_q, dim_cnt_d;

    assign eff      = req & req_en;
    // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority requester.
    assign eff_low  = eff & (~eff + One);
    assign vbl_rise = vblank & ~vblank_prev;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant;
        pause_cpu_d   = pause_cpu;
        paused_d      = paused;
        ack_timeout_d = ack_timeout;
        ack_cnt_d     = '0;
        unique case (state_q)
            StRun: begin
                if (eff != '0) begin
                    state_d = StWaitVbl;
                    grant_d = eff_low;
                end
            end
            StWaitVbl: begin
                if (eff == '0) begin
                    state_d = StRun;
                    grant_d = '0;
                end else begin
                    grant_d = eff_low;
                    if (vbl_rise) begin
                        state_d     = StHalt;
                        pause_cpu_d = 1'b1;
                    end
                end
            end
            StHalt: begin
                // The handshake always completes; a dropped request is handled in StPaused.
                pause_cpu_d = 1'b1;
                ack_cnt_d   = ack_cnt_q + 32'd1;
                if (halt_ack) begin
                    state_d  = StPaused;
                    paused_d = 1'b1;
                end else if (ack_cnt_q == ACK_TO - 1) begin
                    state_d       = StPaused;
                    paused_d      = 1'b1;
                    ack_timeout_d = 1'b1;
                end
            end
            StPaused: begin
                if (eff == '0) begin
                    state_d     = StRelease;
                    pause_cpu_d = 1'b0;
                    paused_d    = 1'b0;
                    grant_d     = '0;
                end else begin
                    grant_d = eff_low;
                end
            end
            StRelease: begin
                if (!halt_ack) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Dim runs only while remaining paused, so leaving StPaused clears it on the same edge.
    assign stay_paused = (state_q == StPaused) && (state_d == StPaused);

    always_comb begin
        dim_cnt_d   = '0;
        dim_video_d = 1'b0;
        if (stay_paused && dim_enable) begin
            dim_video_d = (dim_cnt_q == DIM_CYCLES);
            dim_cnt_d   = (dim_cnt_q == DIM_CYCLES) ? dim_cnt_q : dim_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            grant       <= '0;
            pause_cpu   <= 1'b0;
            paused      <= 1'b0;
            dim_video   <= 1'b0;
            ack_timeout <= 1'b0;
            vblank_prev <= 1'b0;
            ack_cnt_q   <= '0;
            dim_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            pause_cpu   <= pause_cpu_d;
            paused      <= paused_d;
            dim_video   <= dim_video_d;
            ack_timeout <= ack_timeout_d;
            vblank_prev <= vblank;
            ack_cnt_q   <= ack_cnt_d;
            dim_cnt_q   <= dim_cnt_d;
        end
    end

endmodule

// File: doc/pause_sequencer.md
# pause_sequencer

Pause controller for arcade cores. It arbitrates up to NREQ pause requesters: user button toggle, hiscore module, OSD-open and save-state engine. The winner's request is turned into a vblank-aligned CPU halt handshake, and video dim is asserted after a programmable hold time. The block sits between the requester logic and the CPU wait/halt input, and drives the dim select of the RGB output path.

## Interface
Parameters:
- NREQ, 4, number of pause requesters; bit 0 is the highest priority.
- ACK_TO, 1024, cycles allowed for the halt acknowledge before a forced pause.
- DIM_CYCLES, 30000000, cycles spent PAUSED before dim (10 s at 3 MHz).

Ports:
- clk_sys  in  1  core system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  level pause requests, active-high.
- req_en  in  NREQ  per-requester enable (OSD options); eff = req & req_en.
- vblank  in  1  vertical blank, synchronous to clk_sys.
- halt_ack  in  1  CPU reports it is halted, active-high.
- dim_enable  in  1  OSD "dim video" option.
- pause_cpu  out  1  halt request to CPU, registered.
- paused  out  1  pause confirmed, registered.
- grant  out  NREQ  one-hot owner of the current pause; 0 when idle.
- dim_video  out  1  dim RGB request, registered.
- ack_timeout  out  1  sticky flag, set when a halt was forced without ack; cleared only by reset.

## Operation
- Reset value of every output is 0. FSM resets to RUN; the dim counter, ack counter and vblank_d reset to 0.
- States: RUN, WAIT_VBL, HALT, PAUSED, RELEASE.
- RUN
  - If eff != 0: go to WAIT_VBL and load grant with the lowest set bit of eff.
- WAIT_VBL
  - If eff == 0: abort to RUN and clear grant.
  - Else, on a vblank rising edge (vblank & ~vblank_d): go to HALT and set pause_cpu=1.
  - While waiting, grant tracks the lowest set bit of eff.
- HALT
  - pause_cpu=1. The ack counter increments each cycle.
  - If halt_ack: go to PAUSED and set paused=1.
  - Else, when the counter reaches ACK_TO-1: go to PAUSED, set paused=1 and set ack_timeout.
  - eff dropping to 0 in HALT does not abort. The full handshake completes first; the release happens in PAUSED.
- PAUSED
  - pause_cpu=1, paused=1. grant updates every cycle to the lowest set bit of eff. This allows an ownership handover without releasing the CPU.
  - If eff == 0: go to RELEASE, drop pause_cpu, paused and dim_video, and clear grant.
- RELEASE
  - Wait for halt_ack == 0, then go to RUN.
  - New requests are ignored until RUN is reached.
  - No timeout in this state.
- Dim counter (32-bit)
  - Counts only in PAUSED with dim_enable=1, saturating at DIM_CYCLES.
  - dim_video=1 while the counter equals DIM_CYCLES.
  - dim_enable low, or leaving PAUSED, clears the counter and dim_video on the next edge.
- Arbitration is fixed priority: the lowest index wins. Simultaneous requests are resolved in the same cycle.
- Asynchronous reset mid-handshake: every output goes to 0 immediately and the FSM returns to RUN; the CPU is released.

## Timing
- All outputs are registered.
- eff edge in RUN -> grant valid 1 cycle later.
- vblank rising edge sampled at edge N -> pause_cpu high after edge N+1.
- halt_ack sampled at edge N -> paused high after edge N+1.
- With no ack, paused rises ACK_TO cycles after entering HALT.
- eff == 0 sampled in PAUSED -> pause_cpu and paused low 1 cycle later.
- dim_video rises DIM_CYCLES+1 cycles after entering PAUSED with dim_enable=1.
- vblank held high when entering WAIT_VBL does not count as an edge. The next rising edge is required.

## Test plan
Run all scenarios with DIM_CYCLES=100 and ACK_TO=16.
- Basic pause: req=4'b0100, req_en=4'b1111, one vblank pulse, halt_ack 3 cycles after pause_cpu -> grant=4'b0100, pause_cpu 1 cycle after the vblank edge, paused 1 cycle after halt_ack.
- Priority and handover: req=4'b1010 -> grant=4'b0010. In PAUSED, drop bit 1 -> grant=4'b1000 next cycle, with pause_cpu held continuously high.
- Abort and masking:
  - req pulses for 5 cycles with no vblank -> WAIT_VBL then RUN, and pause_cpu never rises.
  - req=4'b0001 with req_en=4'b1110 -> no grant.
- Ack timeout: halt_ack held 0 -> paused and ack_timeout rise 16 cycles after HALT entry; ack_timeout stays high after the pause is released.
- Dim:
  - dim_enable=1 -> dim_video rises 101 cycles after PAUSED entry.
  - Deasserting dim_enable -> dim_video falls 1 cycle later.
  - Re-enabling dim_enable -> a full 100-cycle count is needed again.
- Reset during HALT: assert reset asynchronously -> pause_cpu, paused, grant and dim_video are 0 before the next clock edge; after release, a new request restarts from RUN.
